// File: rtl/tsb_enq_arbiter_if.sv
// tsb_enq_arbiter_if
// Bundles the N_PORTS child-manager request channels and the single TSB
// write port seen by tsb_enq_arbiter.
//   s_valid/s_ready   : per-port request handshake
//   s_data            : per-port task (task_t)
//   s_tied            : per-port tied flag
//   s_cq_slot         : per-port CQ slot (cq_slice_slot_t)
//   s_child_id        : per-port child id (child_id_t)
//   m_wvalid/m_wready : registered TSB write handshake
//   m_wdata, m_tied, m_cq_slot, m_child_id : forwarded task fields
//   m_port            : index of the port the held entry came from
// Modports: slave = arbiter side, master = requester/TSB side.
interface tsb_enq_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 64,
  parameter int SLOT_W  = 8,
  parameter int CHILD_W = 8
);
  localparam int PORT_W = $clog2(N_PORTS);

  typedef logic [DATA_W-1:0]  task_t;
  typedef logic [SLOT_W-1:0]  cq_slice_slot_t;
  typedef logic [CHILD_W-1:0] child_id_t;

  logic [N_PORTS-1:0]           s_valid;
  logic [N_PORTS-1:0]           s_ready;
  task_t          [N_PORTS-1:0] s_data;
  logic [N_PORTS-1:0]           s_tied;
  cq_slice_slot_t [N_PORTS-1:0] s_cq_slot;
  child_id_t      [N_PORTS-1:0] s_child_id;

  logic                         m_wvalid;
  logic                         m_wready;
  task_t                        m_wdata;
  logic                         m_tied;
  cq_slice_slot_t               m_cq_slot;
  child_id_t                    m_child_id;
  logic [PORT_W-1:0]            m_port;

  modport slave (
    input  s_valid, s_data, s_tied, s_cq_slot, s_child_id, m_wready,
    output s_ready, m_wvalid, m_wdata, m_tied, m_cq_slot, m_child_id, m_port
  );

  modport master (
    output s_valid, s_data, s_tied, s_cq_slot, s_child_id, m_wready,
    input  s_ready, m_wvalid, m_wdata, m_tied, m_cq_slot, m_child_id, m_port
  );
endinterface

// File: rtl/tsb_enq_arbiter.sv
// tsb_enq_arbiter
// Round-robin arbiter that funnels N_PORTS child-manager task requests into
// a single one-entry registered TSB write port (1-cycle latency, one task per
// cycle when the TSB drains every cycle). Counts accepted transfers per port.
// Ports:
//   clk          : clock
//   rstn         : synchronous active-low reset
//   bus          : tsb_enq_arbiter_if.slave (request channels + TSB write port)
//   almost_full  : TSB occupancy warning
//   grant_cnt    : per-port accepted-transfer counters (wrap modulo 2^CNT_W)
// Optional feature: define TSB_ARB_AF_THROTTLE_EN to restrict grants to port 0
// while almost_full is high; otherwise almost_full is ignored.
module tsb_enq_arbiter #(
  parameter int N_PORTS = 4,
  parameter int CNT_W   = 32,
  parameter int DATA_W  = 64,
  parameter int SLOT_W  = 8,
  parameter int CHILD_W = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  tsb_enq_arbiter_if.slave                bus,
  input  logic                            almost_full,
  output logic [N_PORTS-1:0][CNT_W-1:0]   grant_cnt
);
  localparam int PTR_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0] eligible;
  logic [N_PORTS-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               found;
  logic               can_load;
  logic               accept;
  logic [PTR_W-1:0]   rr_ptr;

  logic               vld_p1;
  logic [DATA_W-1:0]  wdata_p1;
  logic               tied_p1;
  logic [SLOT_W-1:0]  slot_p1;
  logic [CHILD_W-1:0] child_p1;
  logic [PTR_W-1:0]   port_p1;

`ifdef TSB_ARB_AF_THROTTLE_EN
  // Under TSB back-pressure only port 0 may enqueue.
  assign eligible = almost_full ? (bus.s_valid & N_PORTS'(1)) : bus.s_valid;
`else
  logic unused_almost_full;
  assign unused_almost_full = almost_full;
  assign eligible = bus.s_valid;
`endif

  // Search starts one past rr_ptr so the last winner has lowest priority.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_PORTS)) sum = sum - (PTR_W+1)'(N_PORTS);
      cand = PTR_W'(sum);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // The output register can take a new entry when empty or draining now.
  assign can_load    = !vld_p1 || bus.m_wready;
  assign accept      = rstn && found && can_load;
  assign bus.s_ready = rstn ? (grant & {N_PORTS{can_load}}) : '0;

  // ---- stage p0 -> p1: accepted request captured into the TSB write register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1    <= 1'b0;
      rr_ptr    <= PTR_W'(N_PORTS-1);
      grant_cnt <= '0;
      wdata_p1  <= '0;
      tied_p1   <= 1'b0;
      slot_p1   <= '0;
      child_p1  <= '0;
      port_p1   <= '0;
    end else begin
      if (accept) begin
        vld_p1               <= 1'b1;
        wdata_p1             <= bus.s_data[grant_idx];
        tied_p1              <= bus.s_tied[grant_idx];
        slot_p1              <= bus.s_cq_slot[grant_idx];
        child_p1             <= bus.s_child_id[grant_idx];
        port_p1              <= grant_idx;
        rr_ptr               <= grant_idx;
        grant_cnt[grant_idx] <= grant_cnt[grant_idx] + CNT_W'(1);
      end else if (bus.m_wready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.m_wvalid   = vld_p1;
  assign bus.m_wdata    = wdata_p1;
  assign bus.m_tied     = tied_p1;
  assign bus.m_cq_slot  = slot_p1;
  assign bus.m_child_id = child_p1;
  assign bus.m_port     = port_p1;
endmodule
